uart_tx_arbiter: RTL

Shares the single uarttx transmitter between NUM_REQ byte producers, for example the CPU OUT path and a debug/trace monitor. Each producer offers a byte on a valid/ready handshake. The arbiter picks one producer, holds the byte stable, pulses tx_start, tracks the transmitter's busy/idle cycle, and reports completion to that producer. It sits between the producers and the uarttx instance, and it replaces the direct ctrl_reg[oi]/alu_out connection.

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart transmitter arbiter: FSM encoding and defaults.
package uart_arb_pkg;

  localparam int STATE_WIDTH      = 2;
  localparam int DEF_BUSY_TIMEOUT = 4;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin / fixed-priority selector over NUM_REQ requests.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  input  logic               fixed_prio,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int start;
    int i;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    i     = 0;
    // Search begins one past the last winner so a held request cannot starve others.
    start = fixed_prio ? 0 : (int'(last) + 1) % NUM_REQ;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (start + k) % NUM_REQ;
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uarttx transmitter among NUM_REQ byte producers via valid/ready,
// driving tx_start/tx_byte and returning a per-requester done pulse.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int WIDTH        = 8,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int FIXED_PRIO   = 0,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       req_done,
  output logic                     tx_start,
  output logic [WIDTH-1:0]         tx_byte,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id
);

  localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q;
  logic [NUM_REQ-1:0] done_d;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last       (last_q),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (pick_grant),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // Holding off while req_done pulses keeps completion and the next accept apart.
  assign accept    = (state_q == IDLE) && tx_ready && !(|req_done) && pick_any;
  assign req_ready = accept ? pick_grant : '0;
  assign tx_start  = (state_q == START);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    case (state_q)
      IDLE: if (accept) state_d = START;
      START: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        // A transmitter that never reports busy is treated as having sent the byte.
        if (!tx_ready || cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_d          = IDLE;
          done_d[grant_id] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_done <= '0;
      tx_byte  <= '0;
      grant_id <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_done <= done_d;
      if (accept) begin
        tx_byte  <= req_data[pick_idx*WIDTH +: WIDTH];
        grant_id <= pick_idx;
        last_q   <= pick_idx;
      end
    end
  end

endmodule
